// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one 64-bit word per line.
// Read hits complete combinationally; misses and stores run a req/ack transaction while stalled.
module data_cache #(
    parameter int unsigned LINES = 8
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [63:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    output logic [63:0] cpu_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned IDX   = $clog2(LINES);
    localparam int unsigned TAG_W = 64 - IDX - 3;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [63:0]        mem_addr_q, mem_addr_d;
    logic [63:0]        mem_wdata_q, mem_wdata_d;

    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [63:0]        data_q [LINES];

    logic [IDX-1:0]     idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               fill_en;
    logic               upd_en;
    logic               unused_addr_lsb;

    assign idx             = cpu_addr[IDX+2:3];
    assign tag             = cpu_addr[63:IDX+3];
    assign hit             = valid_q[idx] && (tag_q[idx] == tag);
    assign unused_addr_lsb = ^cpu_addr[2:0];

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Next state, transaction launch/retire, and the combinational stall / load-data path.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_en     = 1'b0;
        upd_en      = 1'b0;
        stall       = 1'b0;
        cpu_rdata   = 64'(0);

        unique case (state_q)
            IDLE: begin
                if (cpu_write) begin
                    stall       = 1'b1;
                    state_d     = WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {cpu_addr[63:3], 3'b000};
                    mem_wdata_d = cpu_wdata;
                end else if (cpu_read) begin
                    if (hit) begin
                        cpu_rdata = data_q[idx];
                    end else begin
                        stall      = 1'b1;
                        state_d    = FILL;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {cpu_addr[63:3], 3'b000};
                    end
                end
            end
            FILL: begin
                stall = 1'b1;
                if (mem_ack) begin
                    fill_en   = 1'b1;
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                end
            end
            WRITE: begin
                stall = 1'b1;
                if (mem_ack) begin
                    upd_en    = hit;
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            DONE: begin
                // Always return to IDLE so a still-held store is not reissued.
                state_d = IDLE;
                if (cpu_read && hit) begin
                    cpu_rdata = data_q[idx];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and valid bits; reset aborts any transaction in flight.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 64'(0);
            mem_wdata_q <= 64'(0);
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if (fill_en) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset; the valid bits qualify them.
    always_ff @(posedge CLOCK) begin
        if (fill_en) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= mem_rdata;
        end else if (upd_en) begin
            data_q[idx] <= cpu_wdata;
        end
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the pipelined ARM_CPU data-memory port and the Data_Memory backing store. Read hits return data combinationally with no stall. Misses and all stores run a req/ack transaction to backing memory while `stall` freezes the pipeline. 64-bit words, one word per line.

## Interface
- `LINES`, 8: number of cache lines, a power of two ≥ 2; `IDX = log2(LINES)`.
- `CLOCK` in 1: single clock; all state changes on the rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `cpu_read` in 1: load request, from the CPU's memread.
- `cpu_write` in 1: store request, from the CPU's memwrite.
- `cpu_addr` in 64: byte address; bits [2:0] ignored (word aligned).
- `cpu_wdata` in 64: store data.
- `cpu_rdata` out 64: load data, valid while `stall` = 0 with `cpu_read` = 1.
- `stall` out 1: CPU must hold its request stable and not advance while this is 1.
- `mem_req` out 1: backing-memory transaction request.
- `mem_we` out 1: 1 = write transaction, 0 = read transaction.
- `mem_addr` out 64: transaction address, equal to `cpu_addr` with [2:0] = 0.
- `mem_wdata` out 64: write data.
- `mem_rdata` in 64: read data, valid in the cycle `mem_ack` = 1.
- `mem_ack` in 1: transaction complete, sampled on the rising edge.

## Operation
- Address split: index = `cpu_addr[IDX+2:3]`; tag = `cpu_addr[63:IDX+3]`. Each line holds a valid bit, a tag and 64 data bits.
- Hit means the indexed line is valid and its tag matches.
- FSM states:
  - IDLE
  - FILL (read miss)
  - WRITE (store)
  - DONE (one cycle; the held request completes here)
- IDLE with `cpu_write` = 1 (write has priority if both requests are asserted):
  - `stall` = 1, combinationally.
  - Next state is WRITE.
- IDLE with `cpu_read` = 1 and a hit: `stall` = 0 and `cpu_rdata` = line data, both combinational; state stays IDLE.
- IDLE with `cpu_read` = 1 and a miss: `stall` = 1; next state is FILL.
- IDLE with no request: `stall` = 0; state stays IDLE.
- FILL:
  - `mem_req` = 1, `mem_we` = 0, `stall` = 1.
  - On an edge with `mem_ack` = 1: line gets data = `mem_rdata`, the tag and valid = 1; next state is DONE.
- WRITE:
  - `mem_req` = 1, `mem_we` = 1, `mem_wdata` = `cpu_wdata`, `stall` = 1.
  - On an edge with `mem_ack` = 1: if the indexed line hits, its data is updated to `cpu_wdata`; a missing line is left unchanged (no allocate). Next state is DONE.
- DONE:
  - `stall` = 0.
  - For a read, `cpu_rdata` = line data.
  - Next state is always IDLE, whatever the inputs, so a held store is never reissued.
- `mem_req`, `mem_addr` and `mem_wdata` stay constant for the whole FILL or WRITE state. `mem_req` = 0 in IDLE and DONE.
- `mem_ack` is ignored in IDLE and DONE.
- `cpu_rdata` = 0 whenever no read is completing.

## Timing
- Reset (`RESET` = 0), asynchronous:
  - State goes to IDLE and every valid bit is cleared.
  - `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `stall` = 0 and `cpu_rdata` = 0 while no request is present.
- Reset during FILL or WRITE aborts the transaction: `mem_req` drops immediately, and a later `mem_ack` has no effect.
- Read hit: 0 extra cycles.
- Read miss, write hit and write miss, all relative to the request first seen in IDLE in cycle 0:
  - `mem_req` is high from cycle 1.
  - If ack arrives in cycle k (k ≥ 1), DONE is cycle k+1 (`stall` = 0); the stall lasts k+1 cycles.
- `mem_ack` arriving in the same cycle `mem_req` rises is legal, so the minimum penalty is 2 cycles.
- Line replacement on a fill overwrites the line unconditionally; write-through means no writeback is ever needed.
- A request changed by the CPU while `stall` = 1 is a protocol violation; the behaviour is undefined.

## Test plan
- Reset, then a read of 0x40 with memory acking after 3 cycles and `mem_rdata` = 0xDEAD:
  - `stall` high for cycles 0-3, `mem_req` high for cycles 1-3, `mem_addr` = 0x40.
  - Cycle 4: `cpu_rdata` = 0xDEAD with `stall` = 0.
  - An immediate reread of 0x40 hits with 0 stall and no `mem_req`.
- Store 0x1234 to 0x40 after that line is cached, ack in the first cycle:
  - One WRITE with `mem_we` = 1 and `mem_wdata` = 0x1234, followed by DONE.
  - A subsequent read of 0x40 hits and returns 0x1234.
- Store to uncached 0x80 (LINES = 8):
  - A memory write is issued.
  - A following read of 0x80 misses: FILL happens, proving no allocate.
- Conflict, LINES = 8:
  - Read 0x08 (fill 0xA), then read 0x48 (same index 1, fill 0xB), then read 0x08 again.
  - The third read misses and refills, returning 0xA.
- `cpu_read` and `cpu_write` both high:
  - A WRITE transaction is issued, not FILL.
  - Exactly one `mem_req` pulse; the store is not repeated after DONE.
- `RESET` asserted mid-FILL, then an ack delivered after reset is released:
  - `mem_req` falls immediately and the ack is ignored.
  - Rereading the same address misses, since valid bits were cleared.
